// File: rtl/game_timer_pkg.sv
// Shared encodings and BCD helpers for the game round countdown timer.
package game_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    localparam logic [3:0] BCD_ZERO = 4'd0;
    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam bcd2_t      BCD_ONE  = {4'd0, 4'd1};

    // Callers keep value within 0..99.
    function automatic bcd2_t to_bcd(input int unsigned value);
        bcd2_t r;
        r.tens = 4'(value / 10);
        r.ones = 4'(value % 10);
        return r;
    endfunction

    function automatic int unsigned from_bcd(input bcd2_t d);
        return (int'(d.tens) * 10) + int'(d.ones);
    endfunction

    localparam int unsigned ROUND_SECONDS_DEFAULT = 60;
    localparam bcd2_t       ROUND_BCD_DEFAULT     = to_bcd(ROUND_SECONDS_DEFAULT);

endpackage

// File: rtl/timer_tick_gen.sv
// One-second divider: free-runs down while enabled, emits Tick when it reaches
// zero and reloads; Clear forces a fresh CLOCK_FREQUENCY-cycle interval.
module timer_tick_gen #(
    parameter int unsigned CLOCK_FREQUENCY = 50000000
) (
    input  logic ClockIn,
    input  logic Resetn,
    input  logic Enable,
    input  logic Clear,
    output logic Tick
);

    localparam int unsigned CNT_W = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLOCK_FREQUENCY - 1);

    logic [CNT_W-1:0] count;

    assign Tick = Enable && (count == '0);

    always_ff @(posedge ClockIn or negedge Resetn) begin
        if (!Resetn) begin
            count <= RELOAD;
        end else if (Clear) begin
            count <= RELOAD;
        end else if (Enable) begin
            if (count == '0) begin
                count <= RELOAD;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_round_timer_ctrl.sv
// Round sequencer driving the two BCD countdown digits.
// Optional bonus-time adder enabled by defining TIMER_BONUS_EN.
module game_round_timer_ctrl
    import game_timer_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 50000000,
    parameter int unsigned ROUND_SECONDS   = 60,
    parameter int unsigned BONUS_SECONDS   = 5
) (
    input  logic       ClockIn,
    input  logic       Resetn,
    input  logic       Start,
    input  logic       Pause,
    input  logic       BonusReq,
    output logic [3:0] OnesValue,
    output logic [3:0] TensValue,
    output logic       RoundActive,
    output logic       TimeUp,
    output logic [1:0] State
);

    localparam bcd2_t ROUND_BCD = to_bcd(ROUND_SECONDS);

    state_t state, state_next;
    bcd2_t  digits, digits_next;
    logic   time_up_next;
    logic   active_next;
    logic   in_round;
    logic   div_enable;
    logic   tick;
    bcd2_t  bonus_digits;
    logic   bonus_hit;

    function automatic bcd2_t sat99(input int unsigned value);
        return to_bcd((value > 99) ? 99 : value);
    endfunction

    function automatic bcd2_t bcd_dec(input bcd2_t d);
        bcd2_t r;
        r = d;
        if (d.tens == BCD_ZERO && d.ones == BCD_ZERO) begin
            r = d;
        end else if (d.ones == BCD_ZERO) begin
            r.ones = BCD_NINE;
            r.tens = d.tens - 4'd1;
        end else begin
            r.ones = d.ones - 4'd1;
        end
        return r;
    endfunction

    assign in_round = (state == ST_RUN) || (state == ST_PAUSED);
    // Dropping Pause lets the divider advance on that same edge, so a count
    // frozen at zero ticks on the resume cycle.
    assign div_enable = in_round && !Pause && !Start;

    timer_tick_gen #(
        .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
    ) u_tick_gen (
        .ClockIn(ClockIn),
        .Resetn (Resetn),
        .Enable (div_enable),
        .Clear  (Start),
        .Tick   (tick)
    );

`ifdef TIMER_BONUS_EN
    int unsigned bonus_sum;

    always_comb begin
        bonus_sum = from_bcd(digits) + BONUS_SECONDS;
        if (tick) begin
            bonus_sum = bonus_sum - 1;
        end
        bonus_digits = sat99(bonus_sum);
    end

    assign bonus_hit = BonusReq;
`else
    logic unused_bonus;

    assign bonus_digits = '0;
    assign bonus_hit    = 1'b0;
    assign unused_bonus = BonusReq | (BONUS_SECONDS > 32'd99);
`endif

    always_comb begin
        state_next   = state;
        digits_next  = digits;
        time_up_next = 1'b0;
        if (Start) begin
            state_next  = ST_RUN;
            digits_next = ROUND_BCD;
        end else if (in_round) begin
            state_next = Pause ? ST_PAUSED : ST_RUN;
            // A bonus absorbs a coincident tick, so it can never expire the round.
            if (bonus_hit) begin
                digits_next = bonus_digits;
            end else if (tick) begin
                if (digits == BCD_ONE) begin
                    digits_next  = '0;
                    state_next   = ST_DONE;
                    time_up_next = 1'b1;
                end else begin
                    digits_next = bcd_dec(digits);
                end
            end
        end
        active_next = (state_next == ST_RUN) || (state_next == ST_PAUSED);
    end

    always_ff @(posedge ClockIn or negedge Resetn) begin
        if (!Resetn) begin
            state       <= ST_IDLE;
            digits      <= '0;
            TimeUp      <= 1'b0;
            RoundActive <= 1'b0;
        end else begin
            state       <= state_next;
            digits      <= digits_next;
            TimeUp      <= time_up_next;
            RoundActive <= active_next;
        end
    end

    assign OnesValue = digits.ones;
    assign TensValue = digits.tens;
    assign State     = state;

endmodule

// File: tb/tb_game_round_timer_ctrl.sv
// Directed bench for game_round_timer_ctrl (CLOCK_FREQUENCY=4, ROUND=12, BONUS=5).
module tb_game_round_timer_ctrl;

    logic       ClockIn = 1'b0;
    logic       Resetn;
    logic       Start;
    logic       Pause;
    logic       BonusReq;
    logic [3:0] OnesValue;
    logic [3:0] TensValue;
    logic       RoundActive;
    logic       TimeUp;
    logic [1:0] State;

    int n_tests = 0;
    int n_fail  = 0;

    game_round_timer_ctrl #(
        .CLOCK_FREQUENCY(4),
        .ROUND_SECONDS  (12),
        .BONUS_SECONDS  (5)
    ) dut (
        .ClockIn    (ClockIn),
        .Resetn     (Resetn),
        .Start      (Start),
        .Pause      (Pause),
        .BonusReq   (BonusReq),
        .OnesValue  (OnesValue),
        .TensValue  (TensValue),
        .RoundActive(RoundActive),
        .TimeUp     (TimeUp),
        .State      (State)
    );

    always #5 ClockIn = ~ClockIn;

    task automatic cycles(input int n);
        repeat (n) @(negedge ClockIn);
    endtask

    // Returns at the negedge after the edge that sampled Start.
    task automatic start_round();
        @(negedge ClockIn);
        Start = 1'b1;
        @(negedge ClockIn);
        Start = 1'b0;
    endtask

    task automatic test_reset();
        Resetn = 1'b0; Start = 1'b0; Pause = 1'b0; BonusReq = 1'b0;
        cycles(3);
        Resetn = 1'b1;
        cycles(20);
        n_tests++;
        if (State !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", State); end
        n_tests++;
        if ({TensValue, OnesValue} !== 8'h00) begin n_fail++; $display("FAIL reset_digits got %h want 00", {TensValue, OnesValue}); end
        n_tests++;
        if (RoundActive !== 1'b0 || TimeUp !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got active=%b timeup=%b want 0 0", RoundActive, TimeUp);
        end
    endtask

    task automatic test_countdown();
        start_round();
        n_tests++;
        if (State !== 2'd1 || {TensValue, OnesValue} !== 8'h12 || RoundActive !== 1'b1) begin
            n_fail++; $display("FAIL start_load got st=%0d dig=%h act=%b want 1 12 1", State, {TensValue, OnesValue}, RoundActive);
        end
        cycles(3);
        n_tests++;
        if ({TensValue, OnesValue} !== 8'h12) begin n_fail++; $display("FAIL early_tick got %h want 12", {TensValue, OnesValue}); end
        cycles(1);
        n_tests++;
        if ({TensValue, OnesValue} !== 8'h11) begin n_fail++; $display("FAIL first_tick got %h want 11", {TensValue, OnesValue}); end
        cycles(8);
        n_tests++;
        if ({TensValue, OnesValue} !== 8'h09) begin n_fail++; $display("FAIL bcd_borrow got %h want 09", {TensValue, OnesValue}); end
        cycles(35);
        n_tests++;
        if ({TensValue, OnesValue} !== 8'h01 || TimeUp !== 1'b0 || State !== 2'd1) begin
            n_fail++; $display("FAIL before_expiry got dig=%h tu=%b st=%0d want 01 0 1", {TensValue, OnesValue}, TimeUp, State);
        end
        cycles(1);
        n_tests++;
        if ({TensValue, OnesValue} !== 8'h00 || State !== 2'd3 || TimeUp !== 1'b1 || RoundActive !== 1'b0) begin
            n_fail++; $display("FAIL expiry got dig=%h st=%0d tu=%b act=%b want 00 3 1 0",
                               {TensValue, OnesValue}, State, TimeUp, RoundActive);
        end
        cycles(1);
        n_tests++;
        if (TimeUp !== 1'b0) begin n_fail++; $display("FAIL timeup_pulse got %b want 0", TimeUp); end
        cycles(10);
        n_tests++;
        if ({TensValue, OnesValue} !== 8'h00 || State !== 2'd3) begin
            n_fail++; $display("FAIL done_hold got dig=%h st=%0d want 00 3", {TensValue, OnesValue}, State);
        end
    endtask

    task automatic test_pause();
        bit held_ok;
        bit seen;
        start_round();
        n_tests++;
        if (State !== 2'd1 || {TensValue, OnesValue} !== 8'h12) begin
            n_fail++; $display("FAIL restart_from_done got st=%0d dig=%h want 1 12", State, {TensValue, OnesValue});
        end
        cycles(8);
        Pause = 1'b1;
        held_ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge ClockIn);
            if (State !== 2'd2 || {TensValue, OnesValue} !== 8'h10 || RoundActive !== 1'b1) held_ok = 1'b0;
        end
        n_tests++;
        if (!held_ok) begin
            n_fail++; $display("FAIL pause_hold got st=%0d dig=%h want 2 10", State, {TensValue, OnesValue});
        end
        Pause = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge ClockIn);
            if ({TensValue, OnesValue} === 8'h09) seen = 1'b1;
        end
        n_tests++;
        if (!seen || State !== 2'd1) begin
            n_fail++; $display("FAIL pause_resume got dig=%h st=%0d want 09 1", {TensValue, OnesValue}, State);
        end
    endtask

    task automatic test_restart();
        bit tu_seen;
        start_round();
        cycles(28);
        n_tests++;
        if ({TensValue, OnesValue} !== 8'h05) begin n_fail++; $display("FAIL reach_05 got %h want 05", {TensValue, OnesValue}); end
        cycles(2);
        start_round();
        n_tests++;
        if ({TensValue, OnesValue} !== 8'h12 || State !== 2'd1) begin
            n_fail++; $display("FAIL mid_restart got dig=%h st=%0d want 12 1", {TensValue, OnesValue}, State);
        end
        tu_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ClockIn);
            if (TimeUp !== 1'b0) tu_seen = 1'b1;
        end
        n_tests++;
        if ({TensValue, OnesValue} !== 8'h12 || tu_seen) begin
            n_fail++; $display("FAIL restart_hold got dig=%h tu=%b want 12 0", {TensValue, OnesValue}, tu_seen);
        end
        cycles(1);
        n_tests++;
        if ({TensValue, OnesValue} !== 8'h11) begin n_fail++; $display("FAIL restart_tick got %h want 11", {TensValue, OnesValue}); end
    endtask

    task automatic test_async_reset();
        start_round();
        cycles(21);
        n_tests++;
        if ({TensValue, OnesValue} !== 8'h07) begin n_fail++; $display("FAIL reach_07 got %h want 07", {TensValue, OnesValue}); end
        #2;
        Resetn = 1'b0;
        #1;
        n_tests++;
        if (State !== 2'd0 || {TensValue, OnesValue} !== 8'h00 || RoundActive !== 1'b0 || TimeUp !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got st=%0d dig=%h act=%b tu=%b want 0 00 0 0",
                               State, {TensValue, OnesValue}, RoundActive, TimeUp);
        end
        @(negedge ClockIn);
        Resetn = 1'b1;
        cycles(8);
        n_tests++;
        if (State !== 2'd0 || {TensValue, OnesValue} !== 8'h00 || TimeUp !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle got st=%0d dig=%h tu=%b want 0 00 0", State, {TensValue, OnesValue}, TimeUp);
        end
    endtask

`ifdef TIMER_BONUS_EN
    task automatic test_bonus();
        start_round();
        Pause = 1'b1;
        cycles(1);
        BonusReq = 1'b1;
        cycles(17);
        BonusReq = 1'b0;
        n_tests++;
        if ({TensValue, OnesValue} !== 8'h97 || State !== 2'd2) begin
            n_fail++; $display("FAIL bonus_accum got dig=%h st=%0d want 97 2", {TensValue, OnesValue}, State);
        end
        BonusReq = 1'b1;
        cycles(1);
        n_tests++;
        if ({TensValue, OnesValue} !== 8'h99) begin n_fail++; $display("FAIL bonus_sat got %h want 99", {TensValue, OnesValue}); end
        cycles(1);
        BonusReq = 1'b0;
        n_tests++;
        if ({TensValue, OnesValue} !== 8'h99) begin n_fail++; $display("FAIL bonus_sat_hold got %h want 99", {TensValue, OnesValue}); end
        Pause = 1'b0;
        @(negedge ClockIn);
        Start = 1'b1; BonusReq = 1'b1;
        @(negedge ClockIn);
        Start = 1'b0; BonusReq = 1'b0;
        n_tests++;
        if ({TensValue, OnesValue} !== 8'h12) begin n_fail++; $display("FAIL start_beats_bonus got %h want 12", {TensValue, OnesValue}); end
        cycles(44);
        cycles(3);
        BonusReq = 1'b1;
        cycles(1);
        BonusReq = 1'b0;
        n_tests++;
        if ({TensValue, OnesValue} !== 8'h05 || TimeUp !== 1'b0 || State !== 2'd1) begin
            n_fail++; $display("FAIL bonus_on_tick got dig=%h tu=%b st=%0d want 05 0 1", {TensValue, OnesValue}, TimeUp, State);
        end
    endtask
`else
    task automatic test_bonus();
        start_round();
        BonusReq = 1'b1;
        cycles(1);
        BonusReq = 1'b0;
        n_tests++;
        if ({TensValue, OnesValue} !== 8'h12) begin n_fail++; $display("FAIL bonus_ignored got %h want 12", {TensValue, OnesValue}); end
        cycles(43);
        cycles(3);
        BonusReq = 1'b1;
        cycles(1);
        BonusReq = 1'b0;
        n_tests++;
        if ({TensValue, OnesValue} !== 8'h00 || TimeUp !== 1'b1 || State !== 2'd3) begin
            n_fail++; $display("FAIL bonus_ignored_expiry got dig=%h tu=%b st=%0d want 00 1 3", {TensValue, OnesValue}, TimeUp, State);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_countdown();
        test_pause();
        test_restart();
        test_async_reset();
        test_bonus();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
